// File: rtl/adc_sample_capture_pkg.sv
// Shared widths and helpers for the ADC sample capture block.
package adc_capture_pkg;
  localparam int ADC_W          = 8;
  localparam int DECIM_MAX_LOG2 = 4;
  localparam int ACC_W          = ADC_W + DECIM_MAX_LOG2;

  function automatic logic [2:0] clamp_decim(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction
endpackage

// File: rtl/adc_sample_capture_if.sv
// Result stream plus occupancy/overflow status between the capture block and its consumer.
interface adc_sample_capture_if
  import adc_capture_pkg::*;
#(parameter int FIFO_DEPTH = 8);
  logic                          out_valid;
  logic                          out_ready;
  logic [ADC_W-1:0]              out_bits;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          overflow;
  logic                          overflow_clear;

  modport master(output out_valid, out_bits, fifo_count, overflow,
                 input  out_ready, overflow_clear);
  modport slave (input  out_valid, out_bits, fifo_count, overflow,
                 output out_ready, overflow_clear);
endinterface

// File: rtl/adc_sample_capture_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is taken only alongside a pop.
module adc_sample_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr, rd;

  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign rd        = out_valid && out_ready;
  assign wr        = push && (!full || rd);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= push_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/adc_sample_capture.sv
// ADC conversion clock generator, sample capture, 2^N averaging and result FIFO.
module adc_sample_capture
  import adc_capture_pkg::*;
#(
  parameter int DIV_W      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cfg_enable,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [2:0]         cfg_decim_log2,
  output logic               adc_clock,
  input  logic [ADC_W-1:0]   adc_data,
  adc_sample_capture_if.master out
);
  logic [DIV_W-1:0] div_cnt;
  logic             div_hit, fall;
  logic [ADC_W-1:0] sample_q;
  logic             cap_vld;
  logic [2:0]       n_eff, n_q;
  logic             n_chg;
  logic [ACC_W-1:0] acc, sum;
  logic [3:0]       cnt, cnt_max;
  logic             push, pop, drop, fifo_full, ovf_q;
  logic [ADC_W-1:0] push_data;

  assign div_hit = cfg_enable && (div_cnt == cfg_div);
  // Only a divider-driven fall is a conversion edge; a disable-forced drop is not.
  assign fall    = div_hit && adc_clock;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      adc_clock <= 1'b0;
    end else if (!cfg_enable) begin
      div_cnt   <= '0;
      adc_clock <= 1'b0;
    end else if (div_hit) begin
      div_cnt   <= '0;
      adc_clock <= ~adc_clock;
    end else begin
      div_cnt   <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample_q <= '0;
      cap_vld  <= 1'b0;
      n_q      <= '0;
    end else begin
      cap_vld <= fall;
      n_q     <= n_eff;
      if (fall) sample_q <= adc_data;
    end
  end

  // Group length and shift follow the registered N so a group finishes with the N it started under.
  assign n_eff     = clamp_decim(cfg_decim_log2);
  assign n_chg     = (n_eff != n_q);
  assign cnt_max   = 4'((5'd1 << n_q) - 5'd1);
  assign sum       = acc + ACC_W'(sample_q);
  assign push      = cap_vld && (cnt == cnt_max);
  assign push_data = ADC_W'(sum >> n_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
    end else if (!cfg_enable || n_chg || push) begin
      acc <= '0;
      cnt <= '0;
    end else if (cap_vld) begin
      acc <= sum;
      cnt <= cnt + 4'd1;
    end
  end

  adc_sample_fifo #(.W(ADC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .out_valid (out.out_valid),
    .out_ready (out.out_ready),
    .out_data  (out.out_bits),
    .count     (out.fifo_count),
    .full      (fifo_full)
  );

  assign pop  = out.out_valid && out.out_ready;
  assign drop = push && fifo_full && !pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   ovf_q <= 1'b0;
    else if (drop)               ovf_q <= 1'b1;
    else if (out.overflow_clear) ovf_q <= 1'b0;
  end

  assign out.overflow = ovf_q;
endmodule

// File: doc/adc_sample_capture.md
# adc_sample_capture

Digital-side consumer of the 8-bit ADC interface between the `Digital` and `ana` instances inside `core`. It generates the ADC conversion clock `adc_clock`, captures `adc_data` once per conversion, and optionally averages 2^N samples. Results go into a small FIFO that presents a ready/valid stream to the SoC's memory-mapped ADC peripheral. The block lives inside `Digital`, on the core `clock`.

## Interface
- `DIV_W`, default 8: width of the clock divider setting.
- `FIFO_DEPTH`, default 8: number of result entries; must be a power of two, at least 2.
- `clock` (in, 1): core clock; every register is on the rising edge.
- `reset` (in, 1): asynchronous, active-high.
- `cfg_enable` (in, 1): runs the capture engine.
- `cfg_div` (in, `DIV_W`): half-period of `adc_clock`, minus one, in `clock` cycles.
- `cfg_decim_log2` (in, 3): log2 of the averaging count. Values above 4 are treated as 4.
- `adc_clock` (out, 1): ADC conversion clock, driven from a register.
- `adc_data` (in, 8): ADC result. It is stable from the `adc_clock` rise through the next fall.
- `out_valid` (out, 1): the FIFO is non-empty.
- `out_ready` (in, 1): the consumer accepts the head entry.
- `out_bits` (out, 8): head entry, or 0 when the FIFO is empty.
- `fifo_count` (out, $clog2(`FIFO_DEPTH`)+1): current occupancy.
- `overflow` (out, 1): sticky flag meaning a result was dropped.
- `overflow_clear` (in, 1): clears `overflow`.

## Operation
- **Reset values:** `adc_clock`=0, `out_valid`=0, `out_bits`=0, `fifo_count`=0, `overflow`=0. The divider, accumulator and sample counter are all 0.
- **Divider:**
  - When enabled, the counter runs from 0 to `cfg_div`.
  - On reaching `cfg_div` it toggles `adc_clock` and returns to 0.
  - The period of `adc_clock` is therefore 2·(`cfg_div`+1) cycles.
  - `cfg_div` is re-read on every counter reload.
- **Capture edge E:** the edge at which the `adc_clock` register goes from 1 to 0. At E, `adc_data` is registered into `sample_q`.
- **Accumulation, at E+1:**
  - `acc` (12 bits) is updated to `acc`+`sample_q` and `cnt` is incremented.
  - When `cnt` reaches 2^N−1, the result (`acc`+`sample_q`)>>N is pushed (truncating, 8 bits), and `acc` and `cnt` are cleared.
  - With N=0, every sample is pushed directly.
- **Configuration change:** if the effective N changes while enabled (a registered copy is compared), `acc` and `cnt` are cleared on the next cycle. The partial group is discarded.
- **Disable:** when `cfg_enable` is low:
  - `adc_clock` is forced to 0 on the next edge.
  - The divider, `acc` and `cnt` are cleared.
  - Any pending push scheduled for that same edge still completes.
  - FIFO contents and `overflow` are kept.
- **FIFO:** first-word-fall-through; `out_bits` is the head entry.
  - A pop happens when `out_valid` && `out_ready`.
  - A push is accepted when `fifo_count` < `FIFO_DEPTH`, or when a pop happens in the same cycle.
  - Push and pop in the same cycle leave the count unchanged. When full, this is legal and nothing is dropped.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
- **Overflow:**
  - A push while full with no pop drops the result and sets `overflow`.
  - `overflow_clear` clears the flag.
  - If a set and a clear occur in the same cycle, set wins.

## Timing
- `adc_clock` first rises `cfg_div`+1 cycles after `cfg_enable` is seen high, and first falls 2·(`cfg_div`+1) cycles after it.
- Latency from capture edge E of the last sample in a group to `out_valid` high: `out_valid` is high in the cycle after edge E+1, i.e. 2 edges.
- `out_valid` deasserts on the edge that pops the last entry.
- `fifo_count` and `overflow` update on the same edge as the push or pop that changes them.
- Sustained throughput: 1 result per 2·(`cfg_div`+1)·2^N cycles. A consumer holding `out_ready` high never causes an overflow.
- Asserting `reset` mid-operation forces all outputs to their reset values immediately. Operation restarts from idle after deassertion.

## Structure
- **Package `adc_capture_pkg`:**
  - `ADC_W`=8, `DECIM_MAX_LOG2`=4, `ACC_W`=`ADC_W`+`DECIM_MAX_LOG2`=12.
  - A function that clamps `cfg_decim_log2`.
- **Sub-module `adc_sample_fifo`:** a parameterised synchronous FWFT FIFO. It takes push/data in and gives valid/ready/data out, plus count and full.
  - Overflow detection stays in the parent block.
- The parent block contains the divider, the capture register, the accumulator and the overflow logic.

## Test plan
- **Pass-through:** `cfg_div`=0, N=0, `out_ready`=1, ADC model drives 0x10, 0x11, 0x12 on successive rises → `adc_clock` period is 2 cycles and `out_bits` reads 0x10, 0x11, 0x12, each 2 edges after its capture edge.
- **Averaging:** `cfg_div`=3, N=2, samples 10, 20, 30, 41 → exactly one result, 25 (101>>2). No `out_valid` during the first 3 samples.
- **Overflow:** `cfg_div`=0, N=0, `out_ready`=0 → `fifo_count` climbs to 8 and the 9th result sets `overflow`. The head entry is still the 1st sample. A push concurrent with a pop while full keeps `fifo_count`=8 with `overflow` unchanged.
- **Clear versus set:** pulse `overflow_clear` on the same edge as a dropped push → `overflow` stays 1. Pulse it alone → `overflow` becomes 0.
- **Disable mid-group:** N=2, drop `cfg_enable` after 2 samples, then re-enable → `adc_clock` is 0 within 1 cycle. The next result is the mean of 4 fresh samples. FIFO contents are preserved throughout.
- **Reset mid-run:** FIFO holding 5 entries and `adc_clock`=1, assert `reset` asynchronously → `adc_clock`, `out_valid`, `fifo_count` and `overflow` are all 0 before the next `clock` edge.
